// File: rtl/wb_pkg.sv
// Shared encodings and helpers for the RV64 write-back stage.
package wb_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LB      = 3'd1,
    LBU     = 3'd2,
    LH      = 3'd3,
    LHU     = 3'd4,
    LW      = 3'd5,
    LWU     = 3'd6,
    LD      = 3'd7
  } ld_ctrl_e;

  typedef enum logic [1:0] {
    WB_SEL_NONE = 2'd0,
    WB_SEL_PC4  = 2'd1,
    WB_SEL_ALU  = 2'd2,
    WB_SEL_MEM  = 2'd3
  } wb_sel_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  // Number of bytes a load type reads; zero for non-loads.
  function automatic logic [3:0] load_size(input logic [2:0] ctrl);
    logic [3:0] size;
    case (ctrl)
      LB, LBU: size = 4'd1;
      LH, LHU: size = 4'd2;
      LW, LWU: size = 4'd4;
      LD:      size = 4'd8;
      default: size = 4'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Shifts the raw memory doubleword down to the addressed byte, extends it
// according to the load type and flags loads that cross the doubleword.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      off_i,
  input  logic [2:0]      ctrl_i,
  output logic [XLEN-1:0] value_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] shifted;

  // Byte-lane alignment, sign/zero extension and boundary-crossing check.
  always_comb begin
    shifted = data_i >> {off_i, 3'b000};
    value_o = '0;
    case (ctrl_i)
      LB:      value_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LBU:     value_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LH:      value_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LHU:     value_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      LW:      value_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      LWU:     value_o = {{(XLEN-32){1'b0}}, shifted[31:0]};
      LD:      value_o = shifted;
      default: value_o = '0;
    endcase
    misaligned_o = ({1'b0, off_i} + load_size(ctrl_i)) > 4'd8;
  end

endmodule

// File: rtl/pipeline_wb_stage.sv
// Write-back stage: waits for load data, aligns it, picks the write-back
// value, writes the register file, retires and counts instructions.
module pipeline_wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_MEM,
  input  logic [XLEN-1:0] pc_WB,
  input  logic [XLEN-1:0] alu_result_MEM,
  input  logic [XLEN-1:0] mem_data_MEM,
  input  logic            dm_rvalid,
  input  logic [2:0]      dm_rd_ctrl_MEM,
  input  logic            rf_wr_en_MEM,
  input  logic [1:0]      rf_wr_sel_MEM,
  input  logic [4:0]      rd_MEM,
  output logic            stall_WB,
  output logic            rf_wr_en,
  output logic [4:0]      rf_wr_addr,
  output logic [XLEN-1:0] rf_wr_data,
  output logic            retire_valid,
  output logic [XLEN-1:0] retire_pc,
  output logic            misaligned_err,
  output logic            bus_err,
  output logic [63:0]     instret
);

  wb_state_e       state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] holdPc_q, holdAlu_q;
  logic [4:0]      holdRd_q;
  logic [2:0]      holdCtrl_q;
  logic            holdWrEn_q;
  logic [1:0]      holdSel_q;

  logic [XLEN-1:0] curPc, curAlu, loadValue, wbValue;
  logic [4:0]      curRd;
  logic [2:0]      curCtrl;
  logic            curWrEn;
  logic [1:0]      curSel;
  logic            inWait, isLoad, misaligned, timeout;
  logic            capture, complete, misErrD, busErrD;

  logic            rfWrEn_q, retireValid_q, misErr_q, busErr_q;
  logic [4:0]      rfWrAddr_q;
  logic [XLEN-1:0] rfWrData_q, retirePc_q;
  logic [63:0]     instret_q;

  // While waiting, the instruction fields come from the capture registers.
  always_comb begin
    inWait  = (state_q == WAIT_MEM);
    curPc   = inWait ? holdPc_q   : pc_WB;
    curAlu  = inWait ? holdAlu_q  : alu_result_MEM;
    curRd   = inWait ? holdRd_q   : rd_MEM;
    curCtrl = inWait ? holdCtrl_q : dm_rd_ctrl_MEM;
    curWrEn = inWait ? holdWrEn_q : rf_wr_en_MEM;
    curSel  = inWait ? holdSel_q  : rf_wr_sel_MEM;
    isLoad  = (curCtrl != LD_NONE);
    timeout = inWait && (cnt_q == TO_W'(MEM_TIMEOUT - 1));
  end

  wb_load_align #(.XLEN(XLEN)) u_align (
    .data_i       (mem_data_MEM),
    .off_i        (curAlu[2:0]),
    .ctrl_i       (curCtrl),
    .value_o      (loadValue),
    .misaligned_o (misaligned)
  );

  // Write-back value selection.
  always_comb begin
    case (curSel)
      WB_SEL_PC4: wbValue = curPc + XLEN'(4);
      WB_SEL_ALU: wbValue = curAlu;
      WB_SEL_MEM: wbValue = loadValue;
      default:    wbValue = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: park in WAIT_MEM only while a good load has no data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (capture)  state_d = WAIT_MEM;
      WAIT_MEM: if (complete) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs: stall, capture and completion decisions for this cycle.
  always_comb begin
    stall_WB = 1'b0;
    capture  = 1'b0;
    complete = 1'b0;
    busErrD  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_MEM) begin
          if (isLoad && !misaligned && !dm_rvalid) begin
            capture  = 1'b1;
            stall_WB = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        stall_WB = !dm_rvalid;
        if (dm_rvalid) begin
          complete = 1'b1;
        end else if (timeout) begin
          complete = 1'b1;
          busErrD  = 1'b1;
        end
      end
      default: ;
    endcase
    misErrD = complete && misaligned;
  end

  // Timeout counter: cleared on capture, counts every waiting cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (capture)                   cnt_d = '0;
    else if (inWait && !complete)  cnt_d = cnt_q + TO_W'(1);
    else if (complete)             cnt_d = '0;
  end

  // Counter and captured instruction fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      holdPc_q   <= '0;
      holdAlu_q  <= '0;
      holdRd_q   <= '0;
      holdCtrl_q <= '0;
      holdWrEn_q <= 1'b0;
      holdSel_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (capture) begin
        holdPc_q   <= pc_WB;
        holdAlu_q  <= alu_result_MEM;
        holdRd_q   <= rd_MEM;
        holdCtrl_q <= dm_rd_ctrl_MEM;
        holdWrEn_q <= rf_wr_en_MEM;
        holdSel_q  <= rf_wr_sel_MEM;
      end
    end
  end

  // Registered completion: register-file write, retire pulse and counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rfWrEn_q      <= 1'b0;
      rfWrAddr_q    <= '0;
      rfWrData_q    <= '0;
      retireValid_q <= 1'b0;
      retirePc_q    <= '0;
      misErr_q      <= 1'b0;
      busErr_q      <= 1'b0;
      instret_q     <= '0;
    end else begin
      retireValid_q <= complete;
      misErr_q      <= misErrD;
      busErr_q      <= busErrD;
      rfWrEn_q      <= complete && curWrEn && (curRd != 5'd0) && !misErrD && !busErrD;
      if (complete) begin
        rfWrAddr_q <= curRd;
        rfWrData_q <= wbValue;
        retirePc_q <= curPc;
        instret_q  <= instret_q + 64'd1;
      end
    end
  end

  assign rf_wr_en       = rfWrEn_q;
  assign rf_wr_addr     = rfWrAddr_q;
  assign rf_wr_data     = rfWrData_q;
  assign retire_valid   = retireValid_q;
  assign retire_pc      = retirePc_q;
  assign misaligned_err = misErr_q;
  assign bus_err        = busErr_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_pipeline_wb_stage.sv
// Self-checking bench for pipeline_wb_stage with a byte-level reference model.
module tb_pipeline_wb_stage;
  import wb_pkg::*;

  localparam int MEM_TIMEOUT = 16;

  logic        clk, reset;
  logic        valid_MEM, dm_rvalid, rf_wr_en_MEM;
  logic [63:0] pc_WB, alu_result_MEM, mem_data_MEM;
  logic [2:0]  dm_rd_ctrl_MEM;
  logic [1:0]  rf_wr_sel_MEM;
  logic [4:0]  rd_MEM;
  logic        stall_WB, rf_wr_en, retire_valid, misaligned_err, bus_err;
  logic [4:0]  rf_wr_addr;
  logic [63:0] rf_wr_data, retire_pc, instret;

  int errors = 0;
  int checks = 0;
  logic [63:0] expInstret = 0;

  int          obsEdges, obsStalls;
  logic        oWrEn, oRetire, oMis, oBus;
  logic [4:0]  oAddr;
  logic [63:0] oData, oPc, oInstret;

  pipeline_wb_stage dut (
    .clk            (clk),
    .reset          (reset),
    .valid_MEM      (valid_MEM),
    .pc_WB          (pc_WB),
    .alu_result_MEM (alu_result_MEM),
    .mem_data_MEM   (mem_data_MEM),
    .dm_rvalid      (dm_rvalid),
    .dm_rd_ctrl_MEM (dm_rd_ctrl_MEM),
    .rf_wr_en_MEM   (rf_wr_en_MEM),
    .rf_wr_sel_MEM  (rf_wr_sel_MEM),
    .rd_MEM         (rd_MEM),
    .stall_WB       (stall_WB),
    .rf_wr_en       (rf_wr_en),
    .rf_wr_addr     (rf_wr_addr),
    .rf_wr_data     (rf_wr_data),
    .retire_valid   (retire_valid),
    .retire_pc      (retire_pc),
    .misaligned_err (misaligned_err),
    .bus_err        (bus_err),
    .instret        (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run can never hang.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Reference load: pick bytes one at a time, then extend by hand.
  function automatic void refLoad(input logic [2:0] ctrl, input logic [63:0] addr,
                                  input logic [63:0] mem, output logic [63:0] val,
                                  output bit mis);
    int size, off;
    bit sgn;
    size = 0; sgn = 0;
    case (ctrl)
      LB:  begin size = 1; sgn = 1; end
      LBU: size = 1;
      LH:  begin size = 2; sgn = 1; end
      LHU: size = 2;
      LW:  begin size = 4; sgn = 1; end
      LWU: size = 4;
      LD:  size = 8;
      default: size = 0;
    endcase
    off = int'(addr[2:0]);
    mis = (off + size) > 8;
    val = '0;
    for (int i = 0; i < size && (off + i) < 8; i++) val[8*i +: 8] = mem[8*(off+i) +: 8];
    if (sgn && size < 8 && val[8*size-1])
      for (int b = 8*size; b < 64; b++) val[b] = 1'b1;
  endfunction

  task automatic idleInputs();
    valid_MEM = 0; dm_rvalid = 0; rf_wr_en_MEM = 0;
    pc_WB = 0; alu_result_MEM = 0; mem_data_MEM = 0;
    dm_rd_ctrl_MEM = 0; rf_wr_sel_MEM = 0; rd_MEM = 0;
  endtask

  // Present one instruction; data arrives lat cycles later (lat=0: same cycle).
  task automatic applyStimulus(input logic [63:0] pc, input logic [63:0] alu,
                               input logic [63:0] mem, input logic [2:0] ctrl,
                               input logic en, input logic [1:0] sel,
                               input logic [4:0] rd, input int lat);
    int cyc;
    bit done;
    valid_MEM = 1; pc_WB = pc; alu_result_MEM = alu; dm_rd_ctrl_MEM = ctrl;
    rf_wr_en_MEM = en; rf_wr_sel_MEM = sel; rd_MEM = rd;
    dm_rvalid = (lat == 0);
    mem_data_MEM = (lat == 0) ? mem : rand64();
    obsStalls = 0; cyc = 0; done = 0;
    while (!done) begin
      #3;
      if (stall_WB) obsStalls++;
      @(posedge clk); #1;
      cyc++;
      if (retire_valid || cyc > 40) begin
        done = 1;
      end else begin
        valid_MEM = 1'($urandom); pc_WB = rand64(); alu_result_MEM = rand64();
        dm_rd_ctrl_MEM = 3'($urandom); rf_wr_en_MEM = 1'($urandom);
        rf_wr_sel_MEM = 2'($urandom); rd_MEM = 5'($urandom);
        dm_rvalid = (cyc == lat);
        mem_data_MEM = (cyc == lat) ? mem : rand64();
      end
    end
    obsEdges = cyc;
    oRetire = retire_valid; oWrEn = rf_wr_en; oAddr = rf_wr_addr; oData = rf_wr_data;
    oPc = retire_pc; oMis = misaligned_err; oBus = bus_err; oInstret = instret;
    expInstret++;
    idleInputs();
  endtask

  // Reset values with reset held low.
  task automatic test_reset();
    reset = 0;
    idleInputs();
    #2;
    checks++; if (rf_wr_en !== 1'b0)     begin errors++; $display("[TB] FAIL reset_wr_en got=%0h exp=0", rf_wr_en); end
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_retire got=%0h exp=0", retire_valid); end
    checks++; if (instret !== 64'd0)     begin errors++; $display("[TB] FAIL reset_instret got=%0h exp=0", instret); end
    checks++; if ({misaligned_err, bus_err, stall_WB} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got=%0b exp=000", {misaligned_err, bus_err, stall_WB}); end
    checks++; if ({rf_wr_addr, rf_wr_data, retire_pc} !== '0) begin errors++; $display("[TB] FAIL reset_data got addr=%0h data=%0h pc=%0h exp=0", rf_wr_addr, rf_wr_data, retire_pc); end
    @(posedge clk); #1;
    reset = 1;
    expInstret = 0;
  endtask

  // ALU write and single-cycle pulse behaviour.
  task automatic test_alu();
    applyStimulus(64'h1000, 64'h1234, 64'h0, LD_NONE, 1'b1, WB_SEL_ALU, 5'd5, 0);
    checks++; if (obsEdges !== 1)         begin errors++; $display("[TB] FAIL alu_latency got=%0d exp=1", obsEdges); end
    checks++; if (oWrEn !== 1'b1)         begin errors++; $display("[TB] FAIL alu_wr_en got=%0h exp=1", oWrEn); end
    checks++; if (oAddr !== 5'd5)         begin errors++; $display("[TB] FAIL alu_addr got=%0h exp=5", oAddr); end
    checks++; if (oData !== 64'h1234)     begin errors++; $display("[TB] FAIL alu_data got=%0h exp=1234", oData); end
    checks++; if (oInstret !== 64'd1)     begin errors++; $display("[TB] FAIL alu_instret got=%0h exp=1", oInstret); end
    @(posedge clk); #1;
    checks++; if ({retire_valid, rf_wr_en} !== 2'b00) begin errors++; $display("[TB] FAIL alu_pulse got=%0b exp=00", {retire_valid, rf_wr_en}); end
  endtask

  // Zero-wait byte loads, signed and unsigned.
  task automatic test_lb();
    applyStimulus(64'h2000, 64'h8003, 64'h0000_0000_8000_0000, LB, 1'b1, WB_SEL_MEM, 5'd7, 0);
    checks++; if (oData !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("[TB] FAIL lb_data got=%0h exp=ffffffffffffff80", oData); end
    checks++; if (obsStalls !== 0 || obsEdges !== 1) begin errors++; $display("[TB] FAIL lb_nostall got stalls=%0d edges=%0d exp 0/1", obsStalls, obsEdges); end
    applyStimulus(64'h2004, 64'h8003, 64'h0000_0000_8000_0000, LBU, 1'b1, WB_SEL_MEM, 5'd7, 0);
    checks++; if (oData !== 64'h80)       begin errors++; $display("[TB] FAIL lbu_data got=%0h exp=80", oData); end
  endtask

  // Word load that waits three cycles for data.
  task automatic test_lw_wait();
    applyStimulus(64'h3000, 64'h9004, 64'h7654_3210_0000_0000, LW, 1'b1, WB_SEL_MEM, 5'd9, 3);
    checks++; if (obsStalls !== 3)        begin errors++; $display("[TB] FAIL lw_stalls got=%0d exp=3", obsStalls); end
    checks++; if (oData !== 64'h7654_3210) begin errors++; $display("[TB] FAIL lw_data got=%0h exp=76543210", oData); end
    checks++; if (oPc !== 64'h3000)       begin errors++; $display("[TB] FAIL lw_pc got=%0h exp=3000", oPc); end
    checks++; if (oWrEn !== 1'b1 || oAddr !== 5'd9) begin errors++; $display("[TB] FAIL lw_wr got en=%0h addr=%0h exp 1/9", oWrEn, oAddr); end
  endtask

  // Halfword crossing the doubleword: error retire, no stall even without data.
  task automatic test_misaligned();
    applyStimulus(64'h4000, 64'hA007, 64'h0, LH, 1'b1, WB_SEL_MEM, 5'd4, 100);
    checks++; if (oMis !== 1'b1 || oRetire !== 1'b1) begin errors++; $display("[TB] FAIL mis_pulse got mis=%0h ret=%0h exp 1/1", oMis, oRetire); end
    checks++; if (oWrEn !== 1'b0)         begin errors++; $display("[TB] FAIL mis_wr_en got=%0h exp=0", oWrEn); end
    checks++; if (obsStalls !== 0)        begin errors++; $display("[TB] FAIL mis_stall got=%0d exp=0", obsStalls); end
    checks++; if (oInstret !== expInstret) begin errors++; $display("[TB] FAIL mis_instret got=%0h exp=%0h", oInstret, expInstret); end
  endtask

  // Bus timeout, the data-wins boundary, and recovery to IDLE.
  task automatic test_timeout();
    applyStimulus(64'h5000, 64'hB000, 64'h0, LD, 1'b1, WB_SEL_MEM, 5'd6, 100);
    checks++; if (oBus !== 1'b1 || oRetire !== 1'b1) begin errors++; $display("[TB] FAIL to_pulse got bus=%0h ret=%0h exp 1/1", oBus, oRetire); end
    checks++; if (obsEdges !== MEM_TIMEOUT + 1) begin errors++; $display("[TB] FAIL to_latency got=%0d exp=%0d", obsEdges, MEM_TIMEOUT + 1); end
    checks++; if (oWrEn !== 1'b0)         begin errors++; $display("[TB] FAIL to_wr_en got=%0h exp=0", oWrEn); end
    @(posedge clk); #1;
    checks++; if (bus_err !== 1'b0)       begin errors++; $display("[TB] FAIL to_pulse_drop got=%0h exp=0", bus_err); end
    applyStimulus(64'h5100, 64'hB008, 64'hDEAD_BEEF_0BAD_F00D, LD, 1'b1, WB_SEL_MEM, 5'd6, MEM_TIMEOUT);
    checks++; if (oBus !== 1'b0 || oData !== 64'hDEAD_BEEF_0BAD_F00D) begin errors++; $display("[TB] FAIL to_edge got bus=%0h data=%0h exp 0/deadbeef0badf00d", oBus, oData); end
    applyStimulus(64'h5200, 64'h77, 64'h0, LD_NONE, 1'b1, WB_SEL_ALU, 5'd1, 0);
    checks++; if (obsEdges !== 1 || oData !== 64'h77) begin errors++; $display("[TB] FAIL to_recover got edges=%0d data=%0h exp 1/77", obsEdges, oData); end
  endtask

  // Link to x0 with PC wrap.
  task automatic test_pc4_x0();
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, LD_NONE, 1'b1, WB_SEL_PC4, 5'd0, 0);
    checks++; if (oWrEn !== 1'b0 || oRetire !== 1'b1) begin errors++; $display("[TB] FAIL x0_retire got en=%0h ret=%0h exp 0/1", oWrEn, oRetire); end
    checks++; if (oData !== 64'h0)        begin errors++; $display("[TB] FAIL pc4_wrap got=%0h exp=0", oData); end
  endtask

  // Random instruction stream against the reference model.
  task automatic test_random();
    logic [63:0] pc, alu, mem, val, expData;
    logic [2:0] ctrl;
    logic [1:0] sel;
    logic [4:0] rd;
    logic en;
    bit mis, bus, err;
    int lat, expEdges, expStalls;
    for (int n = 0; n < 60; n++) begin
      pc = rand64() & ~64'd3; alu = rand64(); mem = rand64();
      ctrl = 3'($urandom_range(0, 7)); sel = 2'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 31)); en = 1'($urandom_range(0, 1));
      lat = ($urandom_range(0, 9) < 4) ? 0 : int'($urandom_range(1, 18));
      refLoad(ctrl, alu, mem, val, mis);
      bus = 0;
      if (ctrl == LD_NONE || mis || lat == 0) begin
        expEdges = 1; expStalls = 0;
      end else if (lat <= MEM_TIMEOUT) begin
        expEdges = lat + 1; expStalls = lat;
      end else begin
        expEdges = MEM_TIMEOUT + 1; expStalls = MEM_TIMEOUT + 1; bus = 1;
      end
      err = mis || bus;
      case (sel)
        WB_SEL_PC4: expData = pc + 64'd4;
        WB_SEL_ALU: expData = alu;
        WB_SEL_MEM: expData = val;
        default:    expData = 64'd0;
      endcase
      applyStimulus(pc, alu, mem, ctrl, en, sel, rd, lat);
      checks++; if (obsEdges !== expEdges || obsStalls !== expStalls) begin errors++; $display("[TB] FAIL rnd_timing n=%0d got edges=%0d stalls=%0d exp %0d/%0d", n, obsEdges, obsStalls, expEdges, expStalls); end
      checks++; if ({oMis, oBus} !== {mis, bus}) begin errors++; $display("[TB] FAIL rnd_err n=%0d got=%0b exp=%0b", n, {oMis, oBus}, {mis, bus}); end
      checks++; if (oWrEn !== (en && rd != 0 && !err)) begin errors++; $display("[TB] FAIL rnd_wr_en n=%0d got=%0h exp=%0h", n, oWrEn, (en && rd != 0 && !err)); end
      checks++; if (oPc !== pc || oAddr !== rd) begin errors++; $display("[TB] FAIL rnd_pc_addr n=%0d got pc=%0h addr=%0h exp %0h/%0h", n, oPc, oAddr, pc, rd); end
      checks++; if (oInstret !== expInstret) begin errors++; $display("[TB] FAIL rnd_instret n=%0d got=%0h exp=%0h", n, oInstret, expInstret); end
      if (!err) begin
        checks++; if (oData !== expData) begin errors++; $display("[TB] FAIL rnd_data n=%0d ctrl=%0d sel=%0d got=%0h exp=%0h", n, ctrl, sel, oData, expData); end
      end
    end
  endtask

  // Reset while a load is waiting discards it; later data is ignored.
  task automatic test_reset_in_wait();
    valid_MEM = 1; pc_WB = 64'h6000; alu_result_MEM = 64'hC000; dm_rd_ctrl_MEM = LW;
    rf_wr_en_MEM = 1; rf_wr_sel_MEM = WB_SEL_MEM; rd_MEM = 5'd3; dm_rvalid = 0;
    @(posedge clk); #1;
    valid_MEM = 0;
    @(posedge clk); #1;
    checks++; if (stall_WB !== 1'b1)      begin errors++; $display("[TB] FAIL rw_stall got=%0h exp=1", stall_WB); end
    reset = 0;
    #1;
    checks++; if ({rf_wr_en, retire_valid, stall_WB} !== 3'b000) begin errors++; $display("[TB] FAIL rw_outputs got=%0b exp=000", {rf_wr_en, retire_valid, stall_WB}); end
    checks++; if (instret !== 64'd0 || rf_wr_data !== 64'd0 || retire_pc !== 64'd0) begin errors++; $display("[TB] FAIL rw_regs got instret=%0h data=%0h pc=%0h exp 0", instret, rf_wr_data, retire_pc); end
    @(posedge clk); #1;
    reset = 1;
    idleInputs();
    dm_rvalid = 1; mem_data_MEM = rand64();
    @(posedge clk); #1;
    checks++; if (retire_valid !== 1'b0 || instret !== 64'd0) begin errors++; $display("[TB] FAIL rw_ignore got ret=%0h instret=%0h exp 0/0", retire_valid, instret); end
    idleInputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_lw_wait();
    test_misaligned();
    test_timeout();
    test_pc4_x0();
    test_random();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_wb_stage.md
Name: pipeline_wb_stage

Overview:
Write-back stage of the 5-stage RV64 pipeline. It sits directly downstream of the memory-access stage and consumes that stage's registered results: PC, ALU result, raw memory doubleword, rd, rf_wr_en and rf_wr_sel. It waits for variable-latency load data, then aligns and extends it, selects the write-back value, writes the register file and retires the instruction. It also raises a stall while a load is outstanding and counts retired instructions.

Parameters:
XLEN, 64, datapath width
MEM_TIMEOUT, 16, max cycles to wait for dm_rvalid before flagging a bus error
TO_W, 5, timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
valid_MEM  in  1  instruction present from the MEM stage
pc_WB  in  64  instruction PC
alu_result_MEM  in  64  ALU result; also the load address
mem_data_MEM  in  64  aligned doubleword from memory, valid when dm_rvalid=1
dm_rvalid  in  1  memory read data valid
dm_rd_ctrl_MEM  in  3  load type (package encoding)
rf_wr_en_MEM  in  1  register write enable
rf_wr_sel_MEM  in  2  write-data select (package encoding)
rd_MEM  in  5  destination register
stall_WB  out  1  combinational; upstream holds while 1
rf_wr_en  out  1  register-file write enable (registered)
rf_wr_addr  out  5  register-file write address
rf_wr_data  out  64  register-file write data; also the forwarding source
retire_valid  out  1  one-cycle pulse per retired instruction
retire_pc  out  64  PC of the retired instruction
misaligned_err  out  1  one-cycle pulse: load crosses a doubleword boundary
bus_err  out  1  one-cycle pulse: load timed out
instret  out  64  retired-instruction counter

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE. All outputs and the timeout counter become 0. Any held instruction is discarded.
- FSM states: IDLE, WAIT_MEM.
- IDLE, valid_MEM=0: all pulse outputs 0, rf_wr_en=0.
- IDLE, valid_MEM=1, non-load (dm_rd_ctrl_MEM=LD_NONE): complete the instruction; outputs appear on the next edge (latency 1).
- IDLE, valid_MEM=1, load, dm_rvalid=1 in the same cycle: zero-wait case. Complete with latency 1; stall_WB=0.
- IDLE, valid_MEM=1, load, dm_rvalid=0: capture pc, alu_result, rd, ctrl, wr_en, wr_sel; clear the counter; go to WAIT_MEM. stall_WB=1 combinationally in this cycle.
- WAIT_MEM: stall_WB=1; all inputs except dm_rvalid and mem_data_MEM are ignored; counter increments each cycle.
  - dm_rvalid=1: complete using the captured fields; return to IDLE. stall_WB=0 in that cycle, so upstream may advance.
  - counter reaches MEM_TIMEOUT-1 with dm_rvalid=0: pulse bus_err and retire_valid; suppress the write; return to IDLE.
  - dm_rvalid and timeout in the same cycle: dm_rvalid wins.
- dm_rvalid in IDLE with no load presented: ignored.
- Load alignment:
  - off = addr[2:0]; shifted = mem_data >> (off*8).
  - LB/LBU use byte 0 of shifted, sign- or zero-extended. LH/LHU use bytes 0-1. LW/LWU use bytes 0-3. LD uses all 8.
  - Misaligned: off+size > 8. Pulse misaligned_err and retire_valid; suppress the write; no wait is needed (no stall, even if dm_rvalid=0).
- Write-data select:
  - WB_SEL_PC4 gives pc+4 (mod 2^64).
  - WB_SEL_ALU gives alu_result.
  - WB_SEL_MEM gives the extended load data.
  - WB_SEL_NONE gives 0.
- Completion, registered on the edge:
  - rf_wr_en = wr_en & (rd!=0) & no error.
  - rf_wr_addr = rd; rf_wr_data = selected value; retire_valid=1; retire_pc=pc.
  - instret increments by 1 on every retire_valid, including error retires, and wraps modulo 2^64.
- A write to x0 still retires, but rf_wr_en=0.
- Pulse outputs are high for exactly one cycle per completion.

Decomposition:
- Package wb_pkg holds:
  - Load encodings: LD_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, LWU=6, LD=7.
  - Write-select encodings: WB_SEL_NONE=0, WB_SEL_PC4=1, WB_SEL_ALU=2, WB_SEL_MEM=3.
  - Load-size lookup function.
- One combinational sub-module, wb_load_align: inputs data, off, ctrl; outputs extended value and misaligned flag.

Test Plan:
- ALU op, rd=5, alu=0x1234, sel=ALU -> next cycle rf_wr_en=1, addr=5, data=0x1234, retire_valid=1, instret=1.
- LB, addr=...03, dm_rvalid=1, mem_data=0x0000_0000_8000_0000 -> data=0xFFFF_FFFF_FFFF_FF80, no stall. Same case with LBU -> data=0x80.
- LW, addr=...04, dm_rvalid after 3 cycles, data=0x7654_3210_0000_0000 -> stall_WB high 3 cycles, then data=0x7654_3210, retire_pc=captured pc.
- LH at addr=...07 -> misaligned_err pulse, rf_wr_en=0, instret incremented.
- Load with no dm_rvalid -> bus_err pulse at the MEM_TIMEOUT-th WAIT_MEM cycle (16 by default), no write, FSM back to IDLE. JAL-type sel=PC4, rd=0 -> rf_wr_en=0, retire_valid=1.
- Assert reset during WAIT_MEM -> all outputs 0 immediately; a later dm_rvalid is ignored; instret=0.
